finder_pattern_scanner: RTL and testbench

- Produces the row/column finder-pattern hit masks and the start pulse consumed by the cross-pattern center locator.
- Streams the binarized frame buffer twice: a row-major pass, then a column-major pass.
- Run-length encodes each line and tests for the QR finder ratio 1:1:3:1:1 (black:white:black:white:black).
- On a match, sets the mask bit at the center coordinate of the 3-unit run.

---
 rtl/finder_pattern_scanner_pkg.sv | 58 +++++
 rtl/finder_run_matcher.sv | 97 +++++++++
 rtl/finder_pattern_scanner.sv | 221 ++++++++++++++++++++++
 tb/tb_finder_pattern_scanner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/finder_pattern_scanner_pkg.sv
// Shared types and constants for the finder-pattern scanner: scan FSM states,
// pixel colours, address width, run/read-tag records and the 1:1:3:1:1 ratio test.
package finder_pattern_scanner_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROW_SCAN,
      S_ROW_FLUSH,
      S_COL_SCAN,
      S_COL_FLUSH,
      S_DONE
   } scan_state_t;

   localparam logic PIXEL_BLACK = 1'b0;
   localparam logic PIXEL_WHITE = 1'b1;

   localparam int unsigned ADDR_W = 20;
   localparam int unsigned RUN_W  = 9;
   localparam int unsigned POS_W  = 16;

   localparam logic [RUN_W-1:0] RUN_MAX = '1;

   typedef struct packed {
      logic             color;
      logic [RUN_W-1:0] length;
      logic [POS_W-1:0] start;
   } run_hist_t;

   typedef struct packed {
      logic             valid;
      logic [POS_W-1:0] pos;
      logic             last;
   } rd_tag_t;

   // r2 is the wide centre run; the other four are the unit-width runs.
   function automatic logic ratio_match(input logic [RUN_W-1:0] r0,
                                        input logic [RUN_W-1:0] r1,
                                        input logic [RUN_W-1:0] r2,
                                        input logic [RUN_W-1:0] r3,
                                        input logic [RUN_W-1:0] r4);
      logic [13:0] s;
      logic [13:0] s3;
      logic [13:0] e0, e1, e3, e4;
      logic        small_ok;
      logic        big_ok;
      s  = 14'(r0) + 14'(r1) + 14'(r3) + 14'(r4);
      s3 = s * 14'd3;
      e0 = {2'b00, r0, 3'b000};
      e1 = {2'b00, r1, 3'b000};
      e3 = {2'b00, r3, 3'b000};
      e4 = {2'b00, r4, 3'b000};
      small_ok = (e0 >= s) && (e0 <= s3) && (e1 >= s) && (e1 <= s3) &&
                 (e3 >= s) && (e3 <= s3) && (e4 >= s) && (e4 <= s3);
      big_ok   = ({4'b0000, r2, 1'b0} >= s) && (14'(r2) <= s);
      return small_ok && big_ok;
   endfunction

endpackage

// File: rtl/finder_run_matcher.sv
// Per-line run-length tracker: keeps the open run and four completed runs and
// pulses hit/center one cycle after a black run closes on a 1:1:3:1:1 shape.
module finder_run_matcher
   import finder_pattern_scanner_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             pix_valid,
   input  logic             pix_color,
   input  logic [POS_W-1:0] pix_pos,
   input  logic             pix_last,
   output logic             hit,
   output logic [POS_W-1:0] hit_center
);

   run_hist_t             cur_q, cur_d;
   run_hist_t [3:0]       hist_q, hist_d;
   logic                  hit_q, hit_d;
   logic [POS_W-1:0]      center_q, center_d;

   run_hist_t             run_after;
   run_hist_t             close_run;
   run_hist_t [3:0]       hist_after;
   run_hist_t [3:0]       close_hist;
   logic                  chg;
   logic                  close_early;
   logic                  check;
   logic                  shape_ok;

   always_comb begin
      run_after  = cur_q;
      hist_after = hist_q;
      chg        = 1'b0;
      if (cur_q.length == '0) begin
         run_after.color  = pix_color;
         run_after.length = RUN_W'(1);
         run_after.start  = pix_pos;
      end else if (pix_color == cur_q.color) begin
         run_after.length = (cur_q.length == RUN_MAX) ? RUN_MAX : cur_q.length + RUN_W'(1);
      end else begin
         chg              = 1'b1;
         run_after.color  = pix_color;
         run_after.length = RUN_W'(1);
         run_after.start  = pix_pos;
         hist_after       = {cur_q, hist_q[3:1]};
      end

      // A colour change closing a black run and a line end closing a black run
      // are mutually exclusive for one pixel, so only one candidate is tested.
      close_early = chg && (cur_q.color == PIXEL_BLACK);
      close_run   = close_early ? cur_q  : run_after;
      close_hist  = close_early ? hist_q : hist_after;
      check       = pix_valid && (close_early || (pix_last && run_after.color == PIXEL_BLACK));

      shape_ok = (close_hist[0].color == PIXEL_BLACK) && (close_hist[1].color == PIXEL_WHITE) &&
                 (close_hist[2].color == PIXEL_BLACK) && (close_hist[3].color == PIXEL_WHITE) &&
                 (close_hist[0].length != '0) && (close_hist[1].length != '0) &&
                 (close_hist[2].length != '0) && (close_hist[3].length != '0) &&
                 (close_run.color == PIXEL_BLACK);

      hit_d    = check && shape_ok &&
                 ratio_match(close_hist[0].length, close_hist[1].length, close_hist[2].length,
                             close_hist[3].length, close_run.length);
      center_d = hit_d ? close_hist[2].start + POS_W'(close_hist[2].length >> 1) : center_q;

      cur_d  = cur_q;
      hist_d = hist_q;
      if (pix_valid) begin
         if (pix_last) begin
            cur_d  = '0;
            hist_d = '0;
         end else begin
            cur_d  = run_after;
            hist_d = hist_after;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cur_q    <= '0;
         hist_q   <= '0;
         hit_q    <= 1'b0;
         center_q <= '0;
      end else begin
         cur_q    <= cur_d;
         hist_q   <= hist_d;
         hit_q    <= hit_d;
         center_q <= center_d;
      end
   end

   assign hit        = hit_q;
   assign hit_center = center_q;

endmodule

// File: rtl/finder_pattern_scanner.sv
// Two-pass (row then column) finder-pattern scanner over a binarized frame buffer.
// Optional SCAN_STATS_EN adds saturating per-pass match counters.
module finder_pattern_scanner
   import finder_pattern_scanner_pkg::*;
#(
   parameter int WIDTH        = 480,
   parameter int HEIGHT       = 480,
   parameter int READ_LATENCY = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_scan,
   input  logic              pixel_reading,
   output logic [ADDR_W-1:0] address_reading,
   output logic [WIDTH-1:0]  horz_patterns,
   output logic [HEIGHT-1:0] vert_patterns,
   output logic              busy,
   output logic              pattern_valid
`ifdef SCAN_STATS_EN
   ,
   output logic [9:0]        horz_hit_count,
   output logic [9:0]        vert_hit_count
`endif
);

   localparam int unsigned FL_W = $clog2(READ_LATENCY + 1) + 1;

   scan_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [POS_W-1:0]  x_q, x_d;
   logic [POS_W-1:0]  y_q, y_d;
   logic [FL_W-1:0]   flush_q, flush_d;
   logic [WIDTH-1:0]  horz_q, horz_d;
   logic [HEIGHT-1:0] vert_q, vert_d;
   rd_tag_t           pipe_q [READ_LATENCY];
   rd_tag_t           pipe_d [READ_LATENCY];
   rd_tag_t           issue;
   logic              x_end, y_end, flush_end;
   logic              accept;
   logic              row_pass;
   logic              match_clear;
   logic              hit;
   logic [POS_W-1:0]  hit_center;

   assign x_end     = (x_q == POS_W'(WIDTH - 1));
   assign y_end     = (y_q == POS_W'(HEIGHT - 1));
   assign flush_end = (flush_q == FL_W'(READ_LATENCY));
   assign accept    = (state_q == S_IDLE) && start_scan;
   assign row_pass  = (state_q == S_ROW_SCAN) || (state_q == S_ROW_FLUSH);

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:      if (start_scan)     state_d = S_ROW_SCAN;
         S_ROW_SCAN:  if (x_end && y_end) state_d = S_ROW_FLUSH;
         S_ROW_FLUSH: if (flush_end)      state_d = S_COL_SCAN;
         S_COL_SCAN:  if (x_end && y_end) state_d = S_COL_FLUSH;
         S_COL_FLUSH: if (flush_end)      state_d = S_DONE;
         S_DONE:                          state_d = S_IDLE;
         default:                         state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = (state_q == S_ROW_SCAN) || (state_q == S_ROW_FLUSH) ||
                      (state_q == S_COL_SCAN) || (state_q == S_COL_FLUSH);
      pattern_valid = (state_q == S_DONE);
   end

   always_comb begin
      addr_d  = addr_q;
      x_d     = x_q;
      y_d     = y_q;
      flush_d = '0;
      horz_d  = horz_q;
      vert_d  = vert_q;
      issue   = '0;
      unique case (state_q)
         S_IDLE: begin
            addr_d = '0;
            x_d    = '0;
            y_d    = '0;
            if (start_scan) begin
               horz_d = '0;
               vert_d = '0;
            end
         end
         S_ROW_SCAN: begin
            issue.valid = 1'b1;
            issue.pos   = x_q;
            issue.last  = x_end;
            addr_d      = addr_q + ADDR_W'(1);
            if (x_end) begin
               x_d = '0;
               y_d = y_q + POS_W'(1);
            end else begin
               x_d = x_q + POS_W'(1);
            end
            if (x_end && y_end) begin
               addr_d = '0;
               x_d    = '0;
               y_d    = '0;
            end
         end
         S_COL_SCAN: begin
            issue.valid = 1'b1;
            issue.pos   = y_q;
            issue.last  = y_end;
            // Column wrap restarts at the top of the next column: address = x+1.
            if (y_end) begin
               y_d    = '0;
               x_d    = x_q + POS_W'(1);
               addr_d = ADDR_W'(x_q) + ADDR_W'(1);
            end else begin
               y_d    = y_q + POS_W'(1);
               addr_d = addr_q + ADDR_W'(WIDTH);
            end
            if (x_end && y_end) begin
               addr_d = '0;
               x_d    = '0;
               y_d    = '0;
            end
         end
         S_ROW_FLUSH, S_COL_FLUSH: flush_d = flush_end ? '0 : flush_q + FL_W'(1);
         default: ;
      endcase

      if (hit) begin
         if (row_pass) begin
            for (int unsigned i = 0; i < WIDTH; i++)
               if (hit_center == POS_W'(i)) horz_d[i] = 1'b1;
         end else begin
            for (int unsigned i = 0; i < HEIGHT; i++)
               if (hit_center == POS_W'(i)) vert_d[i] = 1'b1;
         end
      end
   end

   always_comb begin
      pipe_d[0] = issue;
      for (int unsigned i = 1; i < READ_LATENCY; i++)
         pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         addr_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         flush_q <= '0;
         horz_q  <= '0;
         vert_q  <= '0;
         for (int unsigned i = 0; i < READ_LATENCY; i++)
            pipe_q[i] <= '0;
      end else begin
         addr_q  <= addr_d;
         x_q     <= x_d;
         y_q     <= y_d;
         flush_q <= flush_d;
         horz_q  <= horz_d;
         vert_q  <= vert_d;
         for (int unsigned i = 0; i < READ_LATENCY; i++)
            pipe_q[i] <= pipe_d[i];
      end
   end

   // The matcher's last hit of a pass is consumed on the same edge that clears it.
   assign match_clear = (state_q == S_IDLE) || ((state_q == S_ROW_FLUSH) && flush_end);

   finder_run_matcher u_matcher (
      .clk        (clk_in),
      .rst        (rst_in),
      .clear      (match_clear),
      .pix_valid  (pipe_q[READ_LATENCY-1].valid),
      .pix_color  (pixel_reading),
      .pix_pos    (pipe_q[READ_LATENCY-1].pos),
      .pix_last   (pipe_q[READ_LATENCY-1].last),
      .hit        (hit),
      .hit_center (hit_center)
   );

   assign address_reading = addr_q;
   assign horz_patterns   = horz_q;
   assign vert_patterns   = vert_q;

`ifdef SCAN_STATS_EN
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;

   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (accept) begin
         hcnt_d = '0;
         vcnt_d = '0;
      end else if (hit) begin
         if (row_pass && (hcnt_q != '1))       hcnt_d = hcnt_q + 10'd1;
         else if (!row_pass && (vcnt_q != '1)) vcnt_d = vcnt_q + 10'd1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   assign horz_hit_count = hcnt_q;
   assign vert_hit_count = vcnt_q;
`endif

endmodule

// File: tb/tb_finder_pattern_scanner.sv
// Directed bench for finder_pattern_scanner (32x64 frame, read latency 2) with
// a frame-buffer model and a queue of expected masks popped at pattern_valid.
module tb_finder_pattern_scanner;

   localparam int W   = 32;
   localparam int H   = 64;
   localparam int RL  = 2;
   localparam int N   = W * H;
   localparam int LAT = 2 * N + 2 * (RL + 1) + 1;

   typedef struct {
      logic [W-1:0] h;
      logic [H-1:0] v;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_in;
   logic          start_scan;
   logic          pixel_reading;
   logic [19:0]   address_reading;
   logic [W-1:0]  horz_patterns;
   logic [H-1:0]  vert_patterns;
   logic          busy;
   logic          pattern_valid;
`ifdef SCAN_STATS_EN
   logic [9:0]    horz_hit_count;
   logic [9:0]    vert_hit_count;
`endif

   logic          fb [N];
   logic          rd1, rd2;
   exp_t          sb_q [$];
   int            n_checks = 0;
   int            n_errors = 0;

   always #5 clk = ~clk;

   finder_pattern_scanner #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(RL)) dut (
      .clk_in          (clk),
      .rst_in          (rst_in),
      .start_scan      (start_scan),
      .pixel_reading   (pixel_reading),
      .address_reading (address_reading),
      .horz_patterns   (horz_patterns),
      .vert_patterns   (vert_patterns),
      .busy            (busy),
      .pattern_valid   (pattern_valid)
`ifdef SCAN_STATS_EN
      ,
      .horz_hit_count  (horz_hit_count),
      .vert_hit_count  (vert_hit_count)
`endif
   );

   always @(posedge clk) begin
      rd1 <= (address_reading < 20'(N)) ? fb[address_reading[10:0]] : 1'b1;
      rd2 <= rd1;
   end
   assign pixel_reading = rd2;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_white();
      for (int i = 0; i < N; i++) fb[i] = 1'b1;
   endtask

   task automatic put(input int x, input int y, input logic c);
      fb[y * W + x] = c;
   endtask

   // B W BBB W B starting at (x0, y)
   task automatic put_row_pattern(input int x0, input int y);
      logic [6:0] pat;
      pat = 7'b0100010;
      for (int i = 0; i < 7; i++) put(x0 + i, y, pat[6 - i]);
   endtask

   task automatic run_scan(input string name, input exp_t e, input int repulse_at);
      exp_t got;
      int   cnt;
      logic pv;
      int   extra_pv;
      sb_q.push_back(e);
      start_scan = 1'b1;
      tick();
      start_scan = 1'b0;
      cnt = 1;
      check({name, "_busy_rise"}, 64'(busy), 64'(1));
      check({name, "_mask_clr"}, 64'(horz_patterns), 64'(0));
      pv = 1'b0;
      while (!pv && cnt < LAT + 50) begin
         start_scan = (cnt == repulse_at);
         tick();
         cnt++;
         pv = pattern_valid;
      end
      start_scan = 1'b0;
      check({name, "_pv_seen"}, 64'(pv), 64'(1));
      check({name, "_latency"}, 64'(cnt), 64'(LAT));
      check({name, "_busy_at_pv"}, 64'(busy), 64'(0));
      got = sb_q.pop_front();
      check({name, "_horz"}, 64'(horz_patterns), 64'(got.h));
      check({name, "_vert"}, 64'(vert_patterns), 64'(got.v));
      extra_pv = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (pattern_valid || busy) extra_pv++;
      end
      check({name, "_single_pv"}, 64'(extra_pv), 64'(0));
      check({name, "_horz_hold"}, 64'(horz_patterns), 64'(got.h));
   endtask

   initial begin
      exp_t e;
      int   pv_cnt;
      rst_in     = 1'b1;
      start_scan = 1'b0;
      fill_white();
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_pv", 64'(pattern_valid), 64'(0));
      check("rst_addr", 64'(address_reading), 64'(0));
      check("rst_horz", 64'(horz_patterns), 64'(0));
      check("rst_vert", 64'(vert_patterns), 64'(0));
      rst_in = 1'b0;
      tick();

      // Row 5: B W BBB W B at x=10..16 -> centre column 13
      fill_white();
      put_row_pattern(10, 5);
      e.h = W'(1) << 13;
      e.v = '0;
      run_scan("row5", e, -1);

      // Column 20, rows 40..53: 2:2:6:2:2 -> centre row 47
      fill_white();
      for (int y = 40; y < 54; y++)
         put(20, y, !((y < 42) || (y >= 44 && y < 50) || (y >= 52)));
      e.h = '0;
      e.v = H'(1) << 47;
      run_scan("col20", e, -1);

      // Row 3: 1:1:1:1:1 at x=0..4 -> rejected
      fill_white();
      for (int x = 0; x < 5; x++) put(x, 3, x[0]);
      e.h = '0;
      e.v = '0;
      run_scan("ratio11111", e, -1);

      // Row 0 pattern ends on the last column -> closed by line end, centre 28
      fill_white();
      put_row_pattern(25, 0);
      e.h = W'(1) << 28;
      e.v = '0;
      run_scan("line_end", e, -1);

      // Reset halfway through the row pass
      fill_white();
      put_row_pattern(10, 5);
      start_scan = 1'b1;
      tick();
      start_scan = 1'b0;
      repeat (N / 2) tick();
      check("mid_busy", 64'(busy), 64'(1));
      check("mid_hit", 64'(horz_patterns), 64'(W'(1) << 13));
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_horz", 64'(horz_patterns), 64'(0));
      check("abort_vert", 64'(vert_patterns), 64'(0));
      check("abort_addr", 64'(address_reading), 64'(0));
      pv_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (pattern_valid) pv_cnt++;
         tick();
      end
      check("abort_no_pv", 64'(pv_cnt), 64'(0));
      e.h = W'(1) << 13;
      e.v = '0;
      run_scan("after_abort", e, -1);

      // Second start pulse during the column pass is ignored
      fill_white();
      for (int y = 40; y < 54; y++)
         put(20, y, !((y < 42) || (y >= 44 && y < 50) || (y >= 52)));
      put_row_pattern(10, 5);
      e.h = W'(1) << 13;
      e.v = H'(1) << 47;
      run_scan("repulse", e, N + RL + 200);

      check("sb_empty", 64'(sb_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
